// File: rtl/snn_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snn_acc_pkg
// Purpose  : Shared definitions for the banked synaptic accumulator:
//            FSM state encoding, default widths, saturation limits and the
//            signed saturating-add helper used by the lane adders.
// Ports    : none (package)
// Options  : SYN_SATURATE_EN selects saturating lane adds (see acc_lane_adder)
// Revision : 1.0 - initial banked release
// ============================================================================
package snn_acc_pkg;

    localparam int DEF_DATA_W   = 17;
    localparam int DEF_TAG_BITS = 5;

    // Clamp limits for the default datapath width.
    localparam logic signed [DEF_DATA_W-1:0] SAT_MAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};
    localparam logic signed [DEF_DATA_W-1:0] SAT_MIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_SWAP  = 2'b10
    } acc_state_t;

    // Operands arrive sign-extended to 64 bits; the result is clamped to the
    // range of a w-bit two's-complement number. 64 bits cannot overflow for
    // any sum of two in-range w-bit operands with w < 63.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi) begin
            return hi;
        end else if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/acc_lane_adder.sv
`default_nettype none
// ============================================================================
// Module   : acc_lane_adder
// Purpose  : One combinational lane adder of the accumulator datapath.
//            With SYN_SATURATE_EN defined the sum clamps to the signed
//            DATA_W range; otherwise it wraps modulo 2**DATA_W.
// Ports    : a, b  - signed DATA_W operands
//            sum   - signed DATA_W result
// Options  : SYN_SATURATE_EN
// Revision : 1.0 - initial banked release
// ============================================================================
module acc_lane_adder
    import snn_acc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] sum
);

`ifdef SYN_SATURATE_EN
    assign sum = DATA_W'(sat_add(64'(a), 64'(b), DATA_W));
`else
    assign sum = a + b;
`endif

endmodule
`default_nettype wire

// File: rtl/synaptic_accumulator_banked.sv
`default_nettype none
// ============================================================================
// Module   : synaptic_accumulator_banked
// Purpose  : Synaptic current accumulator with an NxN weight matrix. Each
//            spike tag popped from the FIFO adds its weight row into the
//            next-step currents (i_next), LANES neurons per cycle. An
//            end-of-step swap copies i_next into i and decays i_next by an
//            arithmetic right shift of DECAY_SHIFT.
// Ports    : clk, reset (sync, active-high)
//            ld_en/ld_src_tag/ld_dst_tag/ld_weight - weight write port
//            fifo_empty/fired_tag/req_deq          - show-ahead spike FIFO
//            swap/swap_done                        - timestep boundary
//            busy, state_out                       - status
//            rd_en/rd_tag/rd_valid/rd_data         - current read port
// Options  : SYN_SATURATE_EN - saturating lane adds (wrapping otherwise)
// Revision : 1.0 - initial banked release
// ============================================================================
module synaptic_accumulator_banked
    import snn_acc_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TAG_BITS    = DEF_TAG_BITS,
    parameter int LANES       = 8,
    parameter int DECAY_SHIFT = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ld_en,
    input  logic [TAG_BITS-1:0]        ld_src_tag,
    input  logic [TAG_BITS-1:0]        ld_dst_tag,
    input  logic signed [DATA_W-1:0]   ld_weight,
    input  logic                       fifo_empty,
    input  logic [TAG_BITS-1:0]        fired_tag,
    output logic                       req_deq,
    input  logic                       swap,
    output logic                       swap_done,
    output logic                       busy,
    input  logic                       rd_en,
    input  logic [TAG_BITS-1:0]        rd_tag,
    output logic                       rd_valid,
    output logic signed [DATA_W-1:0]   rd_data,
    output logic [1:0]                 state_out
);

    localparam int N       = 2 ** TAG_BITS;
    localparam int CHUNKS  = N / LANES;
    localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(CHUNKS - 1);

    acc_state_t                state;
    logic [CHUNK_W-1:0]        chunk;
    logic [TAG_BITS-1:0]       cur_tag;
    logic                      swap_pending;
    logic                      last_chunk;
    logic                      accept;

    logic signed [DATA_W-1:0]  weights [N][N];
    logic signed [DATA_W-1:0]  cur_i   [N];   // i: current-step currents
    logic signed [DATA_W-1:0]  next_i  [N];   // i_next: accumulating currents

    logic [TAG_BITS-1:0]       lane_idx [LANES];
    logic signed [DATA_W-1:0]  lane_sum [LANES];

    assign last_chunk = (chunk == LAST_CHUNK);

    // A new spike is taken either from IDLE or on the final chunk of the
    // current row, so consecutive rows run with no idle cycle in between.
    // Reset masks the pop so no FIFO entry is lost while reset is held.
    assign accept  = !reset && !fifo_empty &&
                     ((state == ST_IDLE) || ((state == ST_ACCUM) && last_chunk));
    assign req_deq = accept;

    assign busy      = (state != ST_IDLE) || swap_pending;
    assign state_out = state;

    // Weight matrix: written in any state, visible from the next cycle.
    // A lane reading the same word in the write cycle sees the old value.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            weights[ld_src_tag][ld_dst_tag] <= ld_weight;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_idx[k] = TAG_BITS'(int'(chunk) * LANES + k);

        acc_lane_adder #(
            .DATA_W (DATA_W)
        ) u_adder (
            .a   (next_i[lane_idx[k]]),
            .b   (weights[cur_tag][lane_idx[k]]),
            .sum (lane_sum[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            chunk        <= '0;
            cur_tag      <= '0;
            swap_pending <= 1'b0;
            swap_done    <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            for (int n = 0; n < N; n++) begin
                cur_i[n]  <= '0;
                next_i[n] <= '0;
            end
        end else begin
            swap_done <= 1'b0;
            rd_valid  <= rd_en;
            if (rd_en) begin
                // Reads see i before any swap committing at this same edge.
                rd_data <= cur_i[rd_tag];
            end

            if (swap) begin
                swap_pending <= 1'b1;
            end

            if (accept) begin
                cur_tag <= fired_tag;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_ACCUM;
                        chunk <= '0;
                    end else if (swap_pending) begin
                        // Only reached with the FIFO empty, so the current
                        // step's spikes are always drained before the swap.
                        state <= ST_SWAP;
                    end
                end

                ST_ACCUM: begin
                    for (int k = 0; k < LANES; k++) begin
                        next_i[lane_idx[k]] <= lane_sum[k];
                    end
                    if (last_chunk) begin
                        chunk <= '0;
                        state <= accept ? ST_ACCUM : ST_IDLE;
                    end else begin
                        chunk <= chunk + 1'b1;
                    end
                end

                ST_SWAP: begin
                    for (int n = 0; n < N; n++) begin
                        cur_i[n]  <= next_i[n];
                        next_i[n] <= next_i[n] >>> DECAY_SHIFT;
                    end
                    swap_done    <= 1'b1;
                    // A swap pulse landing in this cycle queues another swap.
                    swap_pending <= swap;
                    state        <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_synaptic_accumulator_banked.sv
`default_nettype none
// ============================================================================
// Module   : tb_synaptic_accumulator_banked
// Purpose  : Self-checking bench for synaptic_accumulator_banked (N=32,
//            LANES=8, DECAY_SHIFT=1). The bench acts as the spike FIFO and
//            keeps a transaction-level model of i / i_next: every popped tag
//            adds its weight row, every swap_done copies and decays.
// Options  : SYN_SATURATE_EN (model follows the same build option)
// Revision : 1.0 - initial release
// ============================================================================
module tb_synaptic_accumulator_banked;

    localparam int DW    = 17;
    localparam int TB    = 5;
    localparam int NN    = 32;
    localparam int LN    = 8;
    localparam int SHIFT = 1;
    localparam longint VMAX = (64'sd1 <<< (DW - 1)) - 1;
    localparam longint VMIN = -(64'sd1 <<< (DW - 1));

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   ld_en;
    logic [TB-1:0]          ld_src_tag;
    logic [TB-1:0]          ld_dst_tag;
    logic signed [DW-1:0]   ld_weight;
    logic                   fifo_empty;
    logic [TB-1:0]          fired_tag;
    logic                   req_deq;
    logic                   swap;
    logic                   swap_done;
    logic                   busy;
    logic                   rd_en;
    logic [TB-1:0]          rd_tag;
    logic                   rd_valid;
    logic signed [DW-1:0]   rd_data;
    logic [1:0]             state_out;

    synaptic_accumulator_banked #(
        .DATA_W      (DW),
        .TAG_BITS    (TB),
        .LANES       (LN),
        .DECAY_SHIFT (SHIFT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ld_en      (ld_en),
        .ld_src_tag (ld_src_tag),
        .ld_dst_tag (ld_dst_tag),
        .ld_weight  (ld_weight),
        .fifo_empty (fifo_empty),
        .fired_tag  (fired_tag),
        .req_deq    (req_deq),
        .swap       (swap),
        .swap_done  (swap_done),
        .busy       (busy),
        .rd_en      (rd_en),
        .rd_tag     (rd_tag),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    longint wm  [NN][NN];
    longint inm [NN];
    longint icm [NN];
    longint exp_q[$];
    int     fifo_q[$];
    bit     do_pop = 0;
    int     cyc = 0;
    int     pops, accum_cnt, swap_cnt, pops_at_swap, first_acc, last_acc;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint add_m(input longint a, input longint b);
        longint s;
        s = a + b;
`ifdef SYN_SATURATE_EN
        if (s > VMAX) s = VMAX;
        else if (s < VMIN) s = VMIN;
`else
        s = s & ((64'sd1 <<< DW) - 1);
        if (s > VMAX) s = s - (64'sd1 <<< DW);
`endif
        return s;
    endfunction

    // Compare process and model update, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            for (int n = 0; n < NN; n++) begin
                inm[n] = 0;
                icm[n] = 0;
            end
            exp_q.delete();
            pops = 0; accum_cnt = 0; swap_cnt = 0; pops_at_swap = 0;
            first_acc = -1; last_acc = -1;
        end else begin
            if (state_out == 2'b01) begin
                accum_cnt++;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            if (swap_done) begin
                for (int n = 0; n < NN; n++) begin
                    icm[n] = inm[n];
                    inm[n] = inm[n] >>> SHIFT;
                end
                swap_cnt++;
                pops_at_swap = pops;
            end
            if (req_deq) begin
                chk("req_deq_nonempty", longint'(fifo_empty), 0);
                for (int n = 0; n < NN; n++) inm[n] = add_m(inm[n], wm[fired_tag][n]);
                pops++;
                do_pop = 1;
            end
            if (rd_valid) begin
                if (exp_q.size() == 0) chk("rd_unexpected", longint'(rd_valid), 0);
                else chk("rd_model", longint'(rd_data), exp_q.pop_front());
            end
            if (rd_en) exp_q.push_back(icm[rd_tag]);
        end
    end

    task automatic refresh();
        fifo_empty = (fifo_q.size() == 0);
        fired_tag  = fifo_empty ? '0 : TB'(fifo_q[0]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (do_pop) begin
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            do_pop = 0;
        end
        swap  = 1'b0;
        ld_en = 1'b0;
        rd_en = 1'b0;
        refresh();
    endtask

    task automatic push(input int t);
        fifo_q.push_back(t);
        refresh();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fifo_q.delete();
        refresh();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input int s, input int d, input longint w);
        ld_en      = 1'b1;
        ld_src_tag = TB'(s);
        ld_dst_tag = TB'(d);
        ld_weight  = DW'(w);
        wm[s][d]   = w;
        tick();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        tick();
        while ((busy || fifo_q.size() != 0 || state_out != 2'b00 || do_pop) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) chk({name, "_timeout"}, n, 0);
        tick();
    endtask

    task automatic wait_accum(input string name);
        int n;
        n = 0;
        while (state_out != 2'b01 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk({name, "_timeout"}, n, 0);
    endtask

    task automatic read_check(input string name, input int t, input longint e);
        rd_en  = 1'b1;
        rd_tag = TB'(t);
        tick();
        chk({name, "_valid"}, longint'(rd_valid), 1);
        chk(name, longint'(rd_data), e);
    endtask

    task automatic read_model(input int t);
        rd_en  = 1'b1;
        rd_tag = TB'(t);
        tick();
    endtask

    task automatic do_swap(input string name);
        swap = 1'b1;
        wait_idle(name);
    endtask

    initial begin
        int busy_low;
        reset = 1'b1; ld_en = 1'b0; ld_src_tag = '0; ld_dst_tag = '0; ld_weight = '0;
        swap = 1'b0; rd_en = 1'b0; rd_tag = '0;
        refresh();
        do_reset();

        // Reset state
        chk("rst_state", state_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_swap_done", swap_done, 0);

        // 1: single spike plus swap
        for (int n = 0; n < NN; n++) load(3, n, n);
        push(3);
        swap = 1'b1;
        wait_idle("t1");
        chk("t1_pops", pops, 1);
        chk("t1_accum_cycles", accum_cnt, NN / LN);
        chk("t1_swaps", swap_cnt, 1);
        chk("t1_pops_before_swap", pops_at_swap, 1);
        read_check("t1_rd5", 5, 5);
        tick();
        chk("t1_rd_valid_pulse", rd_valid, 0);

        // 2: back-to-back rows
        do_reset();
        push(3); push(3); push(3);
        wait_idle("t2");
        chk("t2_accum_cycles", accum_cnt, 12);
        chk("t2_no_gap", last_acc - first_acc + 1, 12);
        do_swap("t2s");
        read_check("t2_rd31", 31, 93);

        // 3: decay shift, positive and negative
        for (int n = 0; n < NN; n++) load(2, n, (n == 0) ? 7 : 0);
        for (int n = 0; n < NN; n++) load(4, n, (n == 0) ? -7 : 0);
        do_reset();
        push(2);
        wait_idle("t3a");
        do_swap("t3b");
        read_check("t3_pos_first", 0, 7);
        do_swap("t3c");
        read_check("t3_pos_second", 0, 3);
        do_reset();
        push(4);
        wait_idle("t3d");
        do_swap("t3e");
        read_check("t3_neg_first", 0, -7);
        do_swap("t3f");
        read_check("t3_neg_second", 0, -4);

        // 4: overflow behaviour
        for (int n = 0; n < NN; n++) load(1, n, (n == 0) ? 65535 : 0);
        do_reset();
        push(1); push(1);
        wait_idle("t4a");
        do_swap("t4b");
`ifdef SYN_SATURATE_EN
        read_check("t4_sat", 0, 65535);
`else
        read_check("t4_wrap", 0, -2);
`endif

        // 5: swap requested mid-ACCUM with two tags queued
        do_reset();
        push(3); push(3);
        tick();
        wait_accum("t5");
        swap = 1'b1;
        busy_low = 0;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (swap_done) break;
            if (!busy) busy_low++;
        end
        chk("t5_busy_low", busy_low, 0);
        chk("t5_swap_done_seen", swap_done, 1);
        tick(); tick(); tick();
        chk("t5_pops_before_swap", pops_at_swap, 2);
        chk("t5_swap_once", swap_cnt, 1);
        read_check("t5_rd10", 10, 20);

        // 6: reset during chunk 2 of ACCUM
        push(3);
        tick();
        wait_accum("t6");
        tick();
        tick();
        reset = 1'b1;
        fifo_q.delete();
        refresh();
        tick();
        chk("t6_state", state_out, 0);
        chk("t6_rd_data", rd_data, 0);
        chk("t6_rd_valid", rd_valid, 0);
        chk("t6_busy", busy, 0);
        reset = 1'b0;
        read_check("t6_i0", 0, 0);
        read_check("t6_i31", 31, 0);
        do_swap("t6s");
        for (int n = 0; n < NN; n++) read_model(n);
        read_check("t6_inext31", 31, 0);

        // Randomised phase against the model
        do_reset();
        for (int s = 0; s < NN; s++) begin
            for (int d = 0; d < NN; d++) begin
                if ($urandom_range(0, 3) == 0)
                    load(s, d, longint'($urandom_range(0, 131071)) + VMIN);
                else
                    load(s, d, longint'($urandom_range(0, 400)) - 200);
            end
        end
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0 && fifo_q.size() < 6) push($urandom_range(0, NN - 1));
            if ($urandom_range(0, 19) == 0) swap = 1'b1;
            if ($urandom_range(0, 2) == 0) begin
                rd_en  = 1'b1;
                rd_tag = TB'($urandom_range(0, NN - 1));
            end
            tick();
        end
        wait_idle("rnd_drain");
        do_swap("rnd_swap");
        for (int n = 0; n < NN; n++) read_model(n);
        tick();
        tick();
        chk("rnd_reads_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/synaptic_accumulator_banked.md
Name: synaptic_accumulator_banked

Overview:
Parametrised successor to the all-parallel synaptic current accumulator. Holds the NxN efferent weight matrix and per-neuron next-step current (i_next) and current-step current (i). Each fired tag popped from the spike FIFO adds its weight row into i_next using LANES adders per cycle, so adder count is decoupled from neuron count. Arithmetic is signed and saturating, and the end-of-step swap applies a parametrised decay shift. Sits between the spike tag FIFO and the neuron update engine, which reads i by tag.

Parameters:
DATA_W, 17, two's-complement width of weights and currents
TAG_BITS, 5, neuron tag width; N = 2**TAG_BITS neurons
LANES, 8, adders per cycle; must divide N; LANES = N gives single-cycle rows
DECAY_SHIFT, 1, arithmetic right shift applied to i_next at swap; 0 means no decay

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
ld_en  in  1  weight write strobe
ld_src_tag  in  TAG_BITS  weight row (efferent/source)
ld_dst_tag  in  TAG_BITS  weight column (afferent/destination)
ld_weight  in  DATA_W  weight value
fifo_empty  in  1  spike FIFO empty
fired_tag  in  TAG_BITS  FIFO head (show-ahead)
req_deq  out  1  pops FIFO head this cycle
swap  in  1  end-of-timestep pulse
swap_done  out  1  one-cycle pulse on the cycle i is updated
busy  out  1  state != IDLE or swap pending
rd_en  in  1  current read request
rd_tag  in  TAG_BITS  neuron to read
rd_valid  out  1  rd_data valid pulse
rd_data  out  DATA_W  i[rd_tag]
state_out  out  2  FSM state

Behaviour:
- Reset: state IDLE; i, i_next, chunk counter and swap_pending cleared; rd_data=0, rd_valid=0, swap_done=0, req_deq=0. The weight matrix is not reset; the bench loads every weight it uses.
- States: IDLE=00, ACCUM=01, SWAP=10; 11 is unused and returns to IDLE.
- Accept condition: req_deq = (state==IDLE || last ACCUM chunk) && !fifo_empty. Evaluated combinationally; on accept, fired_tag is latched into cur_tag.
- IDLE transitions:
  - accept -> ACCUM with chunk=0.
  - else if swap_pending -> SWAP.
  - else stay in IDLE.
- ACCUM: on each cycle, for k in 0..LANES-1, idx = chunk*LANES+k and i_next[idx] <= sat(i_next[idx] + W[cur_tag][idx]). chunk then increments.
- End of ACCUM: on the last chunk (N/LANES-1), go back-to-back to ACCUM if an accept occurs, else to IDLE. Per-spike latency is N/LANES cycles, and throughput is 1 spike per N/LANES cycles.
- Swap request: a swap pulse in any state sets swap_pending. Swap is serviced only from IDLE with fifo_empty, so spikes of the current step always drain first.
- SWAP (1 cycle), then IDLE:
  - i[n] <= i_next[n] for all n.
  - i_next[n] <= i_next[n] >>> DECAY_SHIFT (sign-preserving).
  - swap_done pulses and swap_pending clears. A swap pulse arriving in that same cycle re-sets pending.
- Saturation: sum clamps to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
- Weight write: ld_en is accepted in any state and lands next cycle. An ACCUM read of the same word in the write cycle uses the old value.
- Read port: rd_en -> next cycle rd_valid=1 and rd_data=i[rd_tag]. rd_data holds its value otherwise. A read in the SWAP cycle returns the pre-swap i.
- reset mid-ACCUM: partial sums are discarded, and the FIFO entry already popped is lost.

Optional Feature:
SYN_SATURATE_EN: when defined, lane adds and swap follow the saturation rule above. When undefined, lane adds wrap modulo 2**DATA_W (legacy behaviour) with smaller adders; the shift is unchanged.

Decomposition:
- Package snn_acc_pkg: state encodings, DATA_W/TAG_BITS defaults, the saturating-add function, and the SAT_MAX/SAT_MIN constants.
- One sub-module, acc_lane_adder, instantiated LANES times: a combinational (sat) adder taking a, b and producing sum.

Test Plan:
1. Load W[3][n]=n for all n, with N=32, LANES=8. Push tag 3 and pulse swap. -> req_deq rises once; 4 ACCUM cycles, then SWAP; swap_done pulses; read tag 5 -> rd_data=5 and rd_valid high 1 cycle later.
2. Push tags 3,3,3 back-to-back. -> 12 consecutive ACCUM cycles with no IDLE gap; after swap, i[31]=93.
3. With i_next[0]=7 and DECAY_SHIFT=1, swap twice with no spikes. -> i[0]=7 then 3. Repeat with -7 -> -7 then -4.
4. Set W[1][0]=65535 and push tag 1 twice. -> with SYN_SATURATE_EN, i[0]=65535 after swap. Without it, the result wraps to -2.
5. Pulse swap while in ACCUM with 2 tags queued. -> busy stays high; both tags are accumulated before SWAP; swap_done occurs exactly once.
6. Assert reset during chunk 2 of ACCUM. -> next cycle state_out=00, all i and i_next are 0, and rd_data=0.
